// File: rtl/wb_imem_loader.sv
// rtl/wb_imem_loader.sv - Wishbone initiator that packs a byte stream into the instruction SRAM
// and optionally verifies the image with a readback checksum.
module wb_imem_loader #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255,
    parameter bit VERIFY  = 1'b1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic [ADDR_W-1:0] wbm_adr_o,
    output logic [31:0]       wbm_dat_o,
    input  logic [31:0]       wbm_dat_i,
    input  logic              wbm_ack_i,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_READ    = 3'd3,
        S_DONE    = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   num_q, num_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       wsum_q, wsum_d;
    logic [31:0]       rsum_q, rsum_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic              s_ready_q, s_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    logic        last;
    logic        ack_ok;
    logic        tmo_hit;
    logic [31:0] rsum_next;

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        adr_d      = adr_q;
        word_d     = word_q;
        idx_d      = idx_q;
        wsum_d     = wsum_q;
        rsum_d     = rsum_q;
        tmo_d      = tmo_q;
        stb_d      = stb_q;
        done_d     = done_q;
        error_d    = error_q;
        err_addr_d = err_addr_q;

        last      = ({1'b0, adr_q} == (num_q - ONE));
        ack_ok    = stb_q && wbm_ack_i;
        tmo_hit   = stb_q && !wbm_ack_i && (tmo_q == TW'(TIMEOUT - 1));
        rsum_next = rsum_q + wbm_dat_i;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d      = num_words;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_addr_d = '0;
                    adr_d      = '0;
                    wsum_d     = '0;
                    rsum_d     = '0;
                    idx_d      = '0;
                    if (num_words == '0) done_d = 1'b1;
                    else                 state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                // Shift in from the top so byte k lands at [8k+7:8k] after four bytes.
                if (s_valid && s_ready_q) begin
                    word_d = {s_data, word_q[31:8]};
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_WRITE;
                        stb_d   = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (ack_ok) begin
                    stb_d  = 1'b0;
                    wsum_d = wsum_q + word_q;
                    if (!last) begin
                        adr_d   = adr_q + ADDR_W'(1);
                        state_d = S_COLLECT;
                    end else if (VERIFY) begin
                        adr_d   = '0;
                        state_d = S_READ;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else if (tmo_hit) begin
                    stb_d      = 1'b0;
                    state_d    = S_ERROR;
                    error_d    = 1'b1;
                    err_addr_d = adr_q;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_READ: begin
                // stb low here is the mandatory idle cycle between read transfers.
                if (!stb_q) begin
                    stb_d = 1'b1;
                end else if (ack_ok) begin
                    stb_d  = 1'b0;
                    rsum_d = rsum_next;
                    if (!last) begin
                        adr_d = adr_q + ADDR_W'(1);
                    end else if (rsum_next == wsum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_ERROR;
                        error_d    = 1'b1;
                        err_addr_d = '0;
                    end
                end else if (tmo_hit) begin
                    stb_d      = 1'b0;
                    state_d    = S_ERROR;
                    error_d    = 1'b1;
                    err_addr_d = adr_q;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (stb_d && !stb_q) tmo_d = '0;
        we_d      = stb_d && (state_d == S_WRITE);
        s_ready_d = (state_d == S_COLLECT);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            num_q      <= '0;
            adr_q      <= '0;
            word_q     <= '0;
            idx_q      <= '0;
            wsum_q     <= '0;
            rsum_q     <= '0;
            tmo_q      <= '0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            adr_q      <= adr_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            wsum_q     <= wsum_d;
            rsum_q     <= rsum_d;
            tmo_q      <= tmo_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            s_ready_q  <= s_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign wbm_cyc_o = stb_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = {4{stb_q}};
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = word_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_addr  = err_addr_q;
endmodule

// File: tb/tb_wb_imem_loader.sv
// tb/tb_wb_imem_loader.sv - bench for wb_imem_loader: byte source, SRAM responder and reference model
module tb_wb_imem_loader;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   num_words = '0;
    logic              s_valid = 1'b0;
    logic [7:0]        s_data = '0;
    logic              s_ready;
    logic              wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]        wbm_sel_o;
    logic [ADDR_W-1:0] wbm_adr_o;
    logic [31:0]       wbm_dat_o, wbm_dat_i;
    logic              ack = 1'b0;
    logic              busy, done, error;
    logic [ADDR_W-1:0] err_addr;

    always #5 clk = ~clk;

    wb_imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .VERIFY(1'b1)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .num_words(num_words),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(ack), .busy(busy), .done(done),
        .error(error), .err_addr(err_addr)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] adr;
        logic [31:0]       dat;
    } xfer_t;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    xfer_t             wr_log[$];
    logic [ADDR_W-1:0] rd_log[$];
    int                total_acks = 0;
    int                ack_limit = 0;
    logic              corrupt_en = 1'b0;
    logic [ADDR_W-1:0] corrupt_adr = '0;

    int         stb_cycles = 0, cyc_cycles = 0, srdy_cycles = 0, sel_bad = 0, cons_cnt = 0;
    logic [7:0] src_q[$];
    int         cons_base = 0;
    bit         toggle = 1'b0;

    assign wbm_dat_i = mem[wbm_adr_o] ^ ((corrupt_en && wbm_adr_o == corrupt_adr) ? 32'h0000_0100 : 32'h0);

    // SRAM responder: single-cycle ack one cycle after stb, limited to ack_limit acks in total.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack <= 1'b0;
        end else begin
            if (wbm_cyc_o && wbm_stb_o && ack) begin
                if (wbm_we_o) begin
                    mem[wbm_adr_o] = wbm_dat_o;
                    wr_log.push_back({wbm_adr_o, wbm_dat_o});
                end else begin
                    rd_log.push_back(wbm_adr_o);
                end
            end
            if (wbm_cyc_o && wbm_stb_o && !ack && total_acks < ack_limit) begin
                ack <= 1'b1;
                total_acks++;
            end else begin
                ack <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (wbm_stb_o) stb_cycles++;
            if (wbm_cyc_o) cyc_cycles++;
            if (s_ready) srdy_cycles++;
            if (wbm_sel_o !== (wbm_cyc_o ? 4'hF : 4'h0) || wbm_stb_o !== wbm_cyc_o) sel_bad++;
            if (s_valid && s_ready) cons_cnt++;
        end
    end

    always @(negedge clk) begin
        int k;
        k = cons_cnt - cons_base;
        if (k < src_q.size()) begin
            s_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = src_q[k];
        end else begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
        end
    end

    // Reference packing: byte 4i+k of the stream is bits [8k+7:8k] of word i.
    function automatic logic [31:0] exp_word(input int i);
        return {src_q[4*i+3], src_q[4*i+2], src_q[4*i+1], src_q[4*i]};
    endfunction

    task automatic fill_src(input int nbytes);
        src_q.delete();
        for (int i = 0; i < nbytes; i++) src_q.push_back(8'($urandom));
        cons_base = cons_cnt;
    endtask

    task automatic pulse_start(input int n);
        @(negedge clk);
        num_words = (ADDR_W + 1)'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int max_cycles, output bit ok);
        int c = 0;
        while (!(!busy && (done || error)) && c < max_cycles) begin
            @(negedge clk);
            c++;
        end
        ok = (c < max_cycles);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !== '0) begin
            errors++;
            $display("FAIL reset_bus: got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h, want all 0",
                     wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o);
        end
        checks++;
        if ({s_ready, busy, done, error, err_addr} !== '0) begin
            errors++;
            $display("FAIL reset_status: got s_ready=%b busy=%b done=%b error=%b err_addr=%h, want all 0",
                     s_ready, busy, done, error, err_addr);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b s_ready=%b, want 0 0", busy, s_ready);
        end
    endtask

    task automatic test_basic;
        int wb, rb, sb;
        bit ok;
        src_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        cons_base = cons_cnt;
        toggle = 1'b0;
        ack_limit = total_acks + 100000;
        wb = wr_log.size(); rb = rd_log.size(); sb = stb_cycles;
        pulse_start(2);
        pulse_start(5);
        wait_end(500, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout: load did not finish within 500 cycles"); end
        checks++;
        if (wr_log.size() - wb !== 2) begin
            errors++; $display("FAIL basic_nwrites: got %0d, want 2", wr_log.size() - wb);
        end else begin
            checks++;
            if (wr_log[wb] !== {8'h00, 32'h1234_5678}) begin
                errors++; $display("FAIL basic_write0: got %h@%h, want 12345678@00", wr_log[wb].dat, wr_log[wb].adr);
            end
            checks++;
            if (wr_log[wb+1] !== {8'h01, 32'hDEAD_BEEF}) begin
                errors++; $display("FAIL basic_write1: got %h@%h, want deadbeef@01", wr_log[wb+1].dat, wr_log[wb+1].adr);
            end
        end
        checks++;
        if (rd_log.size() - rb !== 2 || rd_log[rb] !== 8'h00 || rd_log[rb+1] !== 8'h01) begin
            errors++; $display("FAIL basic_reads: got %0d reads, want 2 reads at 00,01", rd_log.size() - rb);
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL basic_status: done=%b error=%b, want 1 0", done, error);
        end
        checks++;
        if (stb_cycles - sb !== 8) begin
            errors++; $display("FAIL basic_stb_cycles: got %0d, want 8", stb_cycles - sb);
        end
        checks++;
        if (cons_cnt - cons_base !== 8) begin
            errors++; $display("FAIL basic_consumed: got %0d, want 8", cons_cnt - cons_base);
        end
    endtask

    task automatic test_timeout;
        int wb, sb;
        bit ok;
        fill_src(4);
        ack_limit = total_acks;
        wb = wr_log.size(); sb = stb_cycles;
        pulse_start(1);
        checks++;
        if (done !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL start_clears_sticky: done=%b error=%b, want 0 0", done, error);
        end
        wait_end(600, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL tmo1_wait: load did not end within 600 cycles"); end
        checks++;
        if (stb_cycles - sb !== TIMEOUT) begin
            errors++; $display("FAIL tmo1_stb_cycles: got %0d, want %0d", stb_cycles - sb, TIMEOUT);
        end
        checks++;
        if ({error, done, busy, wbm_cyc_o, wbm_stb_o, err_addr} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++; $display("FAIL tmo1_status: error=%b done=%b busy=%b cyc=%b stb=%b err_addr=%h, want 1 0 0 0 0 00",
                               error, done, busy, wbm_cyc_o, wbm_stb_o, err_addr);
        end

        fill_src(12);
        ack_limit = total_acks + 2;
        wb = wr_log.size(); sb = stb_cycles;
        pulse_start(3);
        wait_end(800, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL tmo3_wait: load did not end within 800 cycles"); end
        checks++;
        if (stb_cycles - sb !== 4 + TIMEOUT) begin
            errors++; $display("FAIL tmo3_stb_cycles: got %0d, want %0d", stb_cycles - sb, 4 + TIMEOUT);
        end
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || err_addr !== 8'h02) begin
            errors++; $display("FAIL tmo3_status: error=%b done=%b err_addr=%h, want 1 0 02", error, done, err_addr);
        end
        checks++;
        if (wr_log.size() - wb !== 2 || wr_log[wb+1] !== {8'h01, exp_word(1)}) begin
            errors++; $display("FAIL tmo3_writes: got %0d writes, want 2 ending with %h@01", wr_log.size() - wb, exp_word(1));
        end
    endtask

    task automatic test_corrupt;
        int wb, rb;
        bit ok;
        fill_src(12);
        ack_limit = total_acks + 100000;
        corrupt_en = 1'b1;
        corrupt_adr = 8'h02;
        wb = wr_log.size(); rb = rd_log.size();
        pulse_start(3);
        wait_end(500, ok);
        corrupt_en = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL corrupt_wait: load did not end within 500 cycles"); end
        checks++;
        if (wr_log.size() - wb !== 3 || rd_log.size() - rb !== 3) begin
            errors++; $display("FAIL corrupt_traffic: got %0d writes %0d reads, want 3 3", wr_log.size() - wb, rd_log.size() - rb);
        end
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || err_addr !== 8'h00) begin
            errors++; $display("FAIL corrupt_status: error=%b done=%b err_addr=%h, want 1 0 00", error, done, err_addr);
        end
    endtask

    task automatic test_zero;
        int cb, rb, c;
        cb = cyc_cycles; rb = srdy_cycles;
        fill_src(8);
        pulse_start(0);
        c = 0;
        while (done !== 1'b1 && c < 2) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL zero_status: done=%b error=%b, want 1 0", done, error);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (cyc_cycles - cb !== 0 || srdy_cycles - rb !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_quiet: cyc cycles=%0d s_ready cycles=%0d busy=%b, want 0 0 0",
                               cyc_cycles - cb, srdy_cycles - rb, busy);
        end
        checks++;
        if (cons_cnt - cons_base !== 0) begin
            errors++; $display("FAIL zero_consumed: got %0d, want 0", cons_cnt - cons_base);
        end
    endtask

    task automatic test_random_full;
        int wb, rb, bad;
        bit ok;
        fill_src(1024 + 8);
        toggle = 1'b1;
        ack_limit = total_acks + 100000;
        wb = wr_log.size(); rb = rd_log.size();
        pulse_start(256);
        wait_end(20000, ok);
        repeat (12) @(negedge clk);
        toggle = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL full_wait: load did not end within 20000 cycles"); end
        checks++;
        if (cons_cnt - cons_base !== 1024) begin
            errors++; $display("FAIL full_consumed: got %0d, want 1024", cons_cnt - cons_base);
        end
        checks++;
        if (wr_log.size() - wb !== 256) begin
            errors++; $display("FAIL full_nwrites: got %0d, want 256", wr_log.size() - wb);
        end else begin
            bad = 0;
            for (int i = 0; i < 256; i++) begin
                checks++;
                if (wr_log[wb+i] !== {8'(i), exp_word(i)}) begin
                    errors++;
                    if (bad < 4) $display("FAIL full_write%0d: got %h@%h, want %h@%h",
                                          i, wr_log[wb+i].dat, wr_log[wb+i].adr, exp_word(i), 8'(i));
                    bad++;
                end
            end
            checks++;
            if (wr_log[wb+255].adr !== 8'hFF) begin
                errors++; $display("FAIL full_last_adr: got %h, want ff", wr_log[wb+255].adr);
            end
        end
        checks++;
        if (rd_log.size() - rb !== 256 || rd_log[rb+255] !== 8'hFF) begin
            errors++; $display("FAIL full_reads: got %0d reads, want 256 ending at ff", rd_log.size() - rb);
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL full_status: done=%b error=%b, want 1 0", done, error);
        end
        checks++;
        if (sel_bad !== 0) begin
            errors++; $display("FAIL sel_cyc_rule: %0d cycles with bad sel/stb, want 0", sel_bad);
        end
    endtask

    task automatic test_reset_mid;
        int wb, c;
        bit ok;
        fill_src(32);
        ack_limit = total_acks + 100000;
        wb = wr_log.size();
        pulse_start(8);
        c = 0;
        while (!(wr_log.size() - wb == 5 && wbm_stb_o && wbm_we_o) && c < 500) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (c >= 500 || wbm_adr_o !== 8'h05) begin
            errors++; $display("FAIL mid_reach_word5: waited %0d cycles adr=%h, want write of word at 05", c, wbm_adr_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, s_ready, busy, done, error, err_addr} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: cyc=%b stb=%b s_ready=%b busy=%b adr=%h, want all outputs 0",
                               wbm_cyc_o, wbm_stb_o, s_ready, busy, wbm_adr_o);
        end
        @(negedge clk);
        rst = 1'b0;
        fill_src(8);
        wb = wr_log.size();
        pulse_start(2);
        wait_end(500, ok);
        checks++;
        if (!ok || done !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL reload_status: finished=%b done=%b error=%b, want 1 1 0", ok, done, error);
        end
        checks++;
        if (wr_log.size() - wb !== 2 || wr_log[wb] !== {8'h00, exp_word(0)} || wr_log[wb+1] !== {8'h01, exp_word(1)}) begin
            errors++; $display("FAIL reload_writes: got %0d writes first %h@%h, want %h@00 and %h@01",
                               wr_log.size() - wb, wr_log[wb].dat, wr_log[wb].adr, exp_word(0), exp_word(1));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_corrupt();
        test_zero();
        test_random_full();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_imem_loader.md
# wb_imem_loader

Wishbone classic initiator that boots the instruction SRAM behind the `vsdmemsoc` Wishbone responder. It accepts a little-endian byte stream, packs four bytes per 32-bit word and writes the words to consecutive word addresses starting at 0. When VERIFY=1 it then reads the image back and compares a running checksum. It sits between the host byte source (UART/SPI front end) and the SoC Wishbone port, and drives the bus only while wb_rst_i of the SoC core is held.

## Interface
- ADDR_W, 8, word-address width; image depth 2^ADDR_W words
- TIMEOUT, 255, max cycles stb may wait for ack before error
- VERIFY, 1, 1 = checksum readback pass after the write pass
- wb_clk_i  in  1  clock, rising edge
- wb_rst_i  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load; ignored while busy
- num_words  in  ADDR_W+1  words to load (0..2^ADDR_W); sampled on accepted start
- s_valid  in  1  byte-stream valid
- s_data  in  8  byte-stream data
- s_ready  out  1  byte accepted when s_valid & s_ready
- wbm_cyc_o  out  1  bus cycle
- wbm_stb_o  out  1  strobe
- wbm_we_o  out  1  1 = write, 0 = read
- wbm_sel_o  out  4  byte select; 4'b1111 during every cycle, 0 otherwise
- wbm_adr_o  out  ADDR_W  word address
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  responder acknowledge
- busy  out  1  load in progress
- done  out  1  sticky success; cleared by next accepted start
- error  out  1  sticky failure (timeout or checksum); cleared by next accepted start
- err_addr  out  ADDR_W  address active at the timeout; 0 on checksum error

## Operation
- Reset: all outputs 0, state IDLE, checksums 0.
- IDLE: start -> latch num_words, clear done/error, adr=0, wsum=0, rsum=0. If num_words=0: set done, stay IDLE, no bus traffic. Otherwise go to COLLECT.
- COLLECT: s_ready=1. The byte index k=0..3 goes to word bits [8k+7:8k]. After the 4th accepted byte go to WRITE.
- WRITE: cyc=stb=we=1, sel=4'hF, adr=current address, dat_o=packed word. Hold until ack is sampled. On ack: wsum+=word (mod 2^32), then drop cyc/stb.
  - More words remain: adr+1, go to COLLECT.
  - Last word and VERIFY=1: adr=0, go to READ.
  - Last word and VERIFY=0: go to DONE.
- READ: cyc=stb=1, we=0, sel=4'hF. On ack: rsum+=wbm_dat_i. After the last word, compare rsum with wsum: equal -> DONE, mismatch -> ERROR (err_addr=0).
- DONE: set done, clear busy, go to IDLE.
- ERROR: set error, clear busy, go to IDLE.
- busy=1 in every state except IDLE.
- Timeout: a counter resets on each stb rising edge and counts stb-high cycles. If it reaches TIMEOUT without ack: drop cyc/stb, err_addr=adr, go to ERROR.
- Address arithmetic: num_words=2^ADDR_W ends at adr=2^ADDR_W-1. The address never wraps during a load.
- s_ready=0 outside COLLECT; bytes presented then are not consumed.

## Timing
- All outputs are registered.
- cyc/stb assert in the cycle after the 4th byte is accepted.
- ack sampled at edge N -> cyc/stb low in cycle N+1. Each transfer has at least one idle cycle, which keeps the responder's single-cycle ack pulse unambiguous.
- With a responder that acks one cycle after stb:
  - each write costs 2 stb cycles + 1 idle;
  - each readback word costs 3 cycles.
- A spurious ack while stb=0 is ignored.
- done/error are set in the cycle after the final ack or after the timeout expires.
- wb_rst_i mid-transfer drops cyc/stb/s_ready immediately (async) and abandons the load.

## Test plan
- num_words=2, bytes 78 56 34 12 EF BE AD DE, responder acks 1 cycle later, VERIFY=1:
  - writes 0x12345678@0 and 0xDEADBEEF@1;
  - reads back 0 and 1;
  - done=1, error=0.
- num_words=1, responder never acks: stb held for TIMEOUT cycles, then cyc/stb=0, error=1, err_addr=0, busy=0.
- num_words=3 with a memory model that corrupts word 2 on readback: checksum mismatch -> error=1, done=0.
- num_words=0: done=1 two cycles after start, cyc never asserts, s_ready stays 0.
- s_valid toggling randomly, num_words=256: exactly 1024 bytes consumed, last write at adr=0xFF, done=1.
- Assert wb_rst_i during the WRITE of word 5: all outputs 0 the same cycle. A new start after release loads again from adr=0.
